// File: rtl/alu_issue_if.sv
// Handshake and ALU-side signal bundle for alu_issue_ctrl.
// Status outputs appear only when ALU_STATUS_EN is defined.
interface alu_issue_if #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_use_acc;
    logic [OPW-1:0]   alu_f;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic [WIDTH-1:0] acc;
`ifdef ALU_STATUS_EN
    logic             out_zero;
    logic [15:0]      op_count;
`endif

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_use_acc, alu_y, out_ready,
        output in_ready, alu_f, alu_a, alu_b, out_valid, out_y, acc
`ifdef ALU_STATUS_EN
        , output out_zero, op_count
`endif
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_use_acc, alu_y, out_ready,
        input  in_ready, alu_f, alu_a, alu_b, out_valid, out_y, acc
`ifdef ALU_STATUS_EN
        , input out_zero, op_count
`endif
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Sequential issue front end for a combinational ALU: one op in flight, result held until consumed.
// Optional status outputs (out_zero, op_count) enabled by defining ALU_STATUS_EN.
module alu_issue_ctrl #(
    parameter int WIDTH   = 8,
    parameter int OPW     = 3,
    parameter int ALU_LAT = 1
) (
    input logic      clk,
    input logic      rst,
    alu_issue_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q;
    logic [OPW-1:0]   f_q;
    logic [WIDTH-1:0] a_q, b_q, y_q, acc_q;
    logic             accept, lat_hit, consume;

    assign accept  = bus.in_valid && (state_q == IDLE);
    assign lat_hit = (state_q == EXEC) && (cnt_q == 4'(ALU_LAT - 1));
    assign consume = (state_q == DONE) && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)  state_d = EXEC;
            EXEC:    if (lat_hit) state_d = DONE;
            DONE:    if (consume) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands stay registered after capture so the ALU inputs only move on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            y_q   <= '0;
            acc_q <= '0;
        end else begin
            if (accept) begin
                f_q   <= bus.in_op;
                b_q   <= bus.in_b;
                a_q   <= bus.in_use_acc ? acc_q : bus.in_a;
                cnt_q <= '0;
            end else if (state_q == EXEC) begin
                cnt_q <= cnt_q + 4'd1;
            end
            if (lat_hit) begin
                y_q   <= bus.alu_y;
                acc_q <= bus.alu_y;
            end
        end
    end

`ifdef ALU_STATUS_EN
    logic        zero_q;
    logic [15:0] cnt_ops_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q    <= 1'b0;
            cnt_ops_q <= '0;
        end else begin
            if (lat_hit) zero_q    <= (bus.alu_y == '0);
            if (consume) cnt_ops_q <= cnt_ops_q + 16'd1;
        end
    end

    assign bus.out_zero = zero_q;
    assign bus.op_count = cnt_ops_q;
`endif

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_y     = y_q;
    assign bus.acc       = acc_q;
    assign bus.alu_f     = f_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: random and directed ops against an arithmetic reference model.
module tb_alu_issue_ctrl;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_issue_if #(.WIDTH(8), .OPW(3)) bus ();

    alu_issue_ctrl #(.WIDTH(8), .OPW(3), .ALU_LAT(LAT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [7:0] alu_stub(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~a;
            3'd6: return a;
            default: return b;
        endcase
    endfunction
    assign bus.alu_y = alu_stub(bus.alu_f, bus.alu_a, bus.alu_b);

    function automatic int ref_alu(input int op, input int a, input int b);
        case (op)
            0: return (a + b) % 256;
            1: return (a - b + 256) % 256;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return 255 - a;
            6: return a;
            default: return b;
        endcase
    endfunction

    typedef struct { int y; int cyc; } exp_t;
    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   model_acc = 0;
    int   model_ops = 0;
    logic hold = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic reset_checks();
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst out_y", 32'(bus.out_y), 32'd0);
        chk("rst acc", 32'(bus.acc), 32'd0);
        chk("rst alu_f", 32'(bus.alu_f), 32'd0);
        chk("rst alu_a", 32'(bus.alu_a), 32'd0);
        chk("rst alu_b", 32'(bus.alu_b), 32'd0);
`ifdef ALU_STATUS_EN
        chk("rst out_zero", 32'(bus.out_zero), 32'd0);
        chk("rst op_count", 32'(bus.op_count), 32'd0);
`endif
    endtask

    task automatic issue(input int op, input int a, input int b, input bit ua);
        int t;
        bit ok;
        exp_t e;
        @(posedge clk); #1;
        bus.in_op      = 3'(op);
        bus.in_a       = 8'(a);
        bus.in_b       = 8'(b);
        bus.in_use_acc = ua;
        bus.in_valid   = 1'b1;
        t  = 0;
        ok = 1'b0;
        while (!ok && t < 200) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            t++;
        end
        if (!ok) begin
            chk("accept timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        e.y   = ref_alu(op, ua ? model_acc : a, b);
        e.cyc = cyc;
        model_acc = e.y;
        q.push_back(e);
    endtask

    // Reset is applied mid-cycle; the monitor flushes its expectations while rst is high.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        reset_checks();
        @(posedge clk); #1;
        model_acc = 0;
        rst = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            bus.out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares handshake, latency and result against the queued expectations.
    initial begin
        bit exp_v;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                model_ops = 0;
                continue;
            end
            chk("in_ready", 32'(bus.in_ready), 32'(q.size() == 0));
            exp_v = (q.size() != 0) && (cyc >= q[0].cyc + LAT);
            chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
`ifdef ALU_STATUS_EN
            chk("op_count", 32'(bus.op_count), 32'(model_ops % 65536));
`endif
            if (bus.out_valid && q.size() != 0) begin
                chk("out_y", 32'(bus.out_y), 32'(q[0].y));
                chk("acc", 32'(bus.acc), 32'(q[0].y));
`ifdef ALU_STATUS_EN
                chk("out_zero", 32'(bus.out_zero), 32'(q[0].y == 0));
`endif
                if (bus.out_ready) begin
                    void'(q.pop_front());
                    model_ops++;
                end
            end
        end
    end

    initial begin
        int t;
        bus.in_valid   = 1'b0;
        bus.in_op      = '0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.in_use_acc = 1'b0;
        bus.out_ready  = 1'b1;
        #1;
        reset_checks();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        issue(0, 5, 3, 1'b0);
        issue(0, 99, 250, 1'b1);
        issue(1, 77, 3, 1'b1);

        // Result held under backpressure while a second request waits.
        hold = 1'b1;
        fork
            begin
                repeat (LAT + 8) @(posedge clk);
                #1 hold = 1'b0;
            end
        join_none
        issue(0, 10, 20, 1'b0);
        issue(1, 9, 4, 1'b0);

        for (int i = 0; i < 40; i++)
            issue($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)));

        issue(0, 200, 100, 1'b0);
        issue(0, 1, 1, 1'b0);
        do_reset();
        issue(0, 0, 6, 1'b1);
        issue(0, 4, 4, 1'b0);

        issue(1, 7, 7, 1'b0);
        issue(0, 0, 0, 1'b1);
        issue(2, 8'hF0, 8'h0F, 1'b0);

        t = 0;
        while (q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (q.size() != 0) chk("drain timeout", 32'(q.size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
